// File: rtl/class_vote_sched.sv
// =============================================================================
// class_vote_sched
// -----------------------------------------------------------------------------
// Time-shares one external combinational decision-tree evaluator across an
// ensemble of per-class trees. For each accepted feature vector the block
// walks every (class, tree) slot, drives the evaluator select lines, samples
// the evaluator's 1-bit vote after EVAL_LAT settle cycles, accumulates votes
// per class and reports the winning class (lowest index wins a tie).
//
// Parameters:
//   N_FEAT    feature vector width
//   N_CLASS   number of classes (>= 2)
//   N_TREE    trees per class (>= 1)
//   EVAL_LAT  settle cycles after a select change before sampling (0..15)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   feature vector valid
//   in_ready   ready for a vector (IDLE and not in reset)
//   in_feat    feature vector
//   ev_feat    registered copy of the accepted vector, to the evaluator
//   ev_class   evaluator class select
//   ev_tree    evaluator tree select
//   ev_result  evaluator vote for the current select
//   out_valid  result valid
//   out_ready  result sink ready
//   out_class  winning class index
//   out_votes  vote count of the winning class
//   out_tie    another class equalled the winner's count
//   perf_count completed output handshakes, saturating
//              (only with CLASS_VOTE_SCHED_PERF_CNT_EN defined)
//
// Build option:
//   CLASS_VOTE_SCHED_PERF_CNT_EN  adds the perf_count port and counter.
// =============================================================================
module class_vote_sched #(
    parameter int N_FEAT   = 51,
    parameter int N_CLASS  = 5,
    parameter int N_TREE   = 2,
    parameter int EVAL_LAT = 1,
    localparam int CW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1,
    localparam int TW = (N_TREE  > 1) ? $clog2(N_TREE)  : 1,
    localparam int VW = $clog2(N_TREE + 1)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_FEAT-1:0] in_feat,

    output logic [N_FEAT-1:0] ev_feat,
    output logic [CW-1:0]     ev_class,
    output logic [TW-1:0]     ev_tree,
    input  logic              ev_result,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_class,
    output logic [VW-1:0]     out_votes,
    output logic              out_tie
`ifdef CLASS_VOTE_SCHED_PERF_CNT_EN
    ,
    output logic [15:0]       perf_count
`endif
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [3:0]    LAT        = 4'(EVAL_LAT);
    localparam logic [CW-1:0] LAST_CLASS = CW'(N_CLASS - 1);
    localparam logic [TW-1:0] LAST_TREE  = TW'(N_TREE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t        state;
    logic [3:0]    wait_cnt;
    logic [VW-1:0] votes [N_CLASS];

    // Running winner over the classes evaluated so far.
    logic [CW-1:0] best_class;
    logic [VW-1:0] best_votes;
    logic          best_tie;

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    logic          accept;
    logic          sample;
    logic          last_tree;
    logic          last_class;
    logic [VW-1:0] cur_count;
    logic [CW-1:0] nb_class;
    logic [VW-1:0] nb_votes;
    logic          nb_tie;

    // in_ready depends on rst directly so it drops in the very cycle reset is
    // asserted, not one cycle later.
    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        sample     = 1'b0;
        last_tree  = 1'b0;
        last_class = 1'b0;
        cur_count  = '0;
        nb_class   = best_class;
        nb_votes   = best_votes;
        nb_tie     = best_tie;

        if (state == EVAL) begin
            sample     = (wait_cnt == LAT);
            last_tree  = (ev_tree == LAST_TREE);
            last_class = (ev_class == LAST_CLASS);
        end

        // Final count of the current class including this cycle's vote.
        cur_count = votes[ev_class] + VW'(ev_result);

        // Candidate winner once this class's last tree is sampled. Class 0
        // seeds the comparison; later classes replace only on a strictly
        // greater count, so ties resolve to the lowest index.
        if (ev_class == '0) begin
            nb_class = '0;
            nb_votes = cur_count;
            nb_tie   = 1'b0;
        end else if (cur_count > best_votes) begin
            nb_class = ev_class;
            nb_votes = cur_count;
            nb_tie   = 1'b0;
        end else if (cur_count == best_votes) begin
            nb_tie   = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Vote counters
    // -------------------------------------------------------------------------
    // NOTE: the counter array carries no reset; it is cleared on every accept
    // and read only during EVAL, so stale contents after reset are never seen.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < N_CLASS; c++) begin
                votes[c] <= '0;
            end
        end else if (sample) begin
            votes[ev_class] <= cur_count;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            ev_feat    <= '0;
            ev_class   <= '0;
            ev_tree    <= '0;
            best_class <= '0;
            best_votes <= '0;
            best_tie   <= 1'b0;
            out_valid  <= 1'b0;
            out_class  <= '0;
            out_votes  <= '0;
            out_tie    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ev_feat  <= in_feat;
                        ev_class <= '0;
                        ev_tree  <= '0;
                        wait_cnt <= '0;
                        state    <= EVAL;
                    end
                end

                EVAL: begin
                    if (!sample) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end else begin
                        wait_cnt <= '0;
                        if (!last_tree) begin
                            ev_tree <= ev_tree + TW'(1);
                        end else begin
                            ev_tree    <= '0;
                            best_class <= nb_class;
                            best_votes <= nb_votes;
                            best_tie   <= nb_tie;
                            if (!last_class) begin
                                ev_class <= ev_class + CW'(1);
                            end else begin
                                // Final slot: selects return to 0 and the
                                // winner is published directly from the
                                // candidate so DONE shows it immediately.
                                ev_class  <= '0;
                                out_class <= nb_class;
                                out_votes <= nb_votes;
                                out_tie   <= nb_tie;
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CLASS_VOTE_SCHED_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Completed-handshake counter, saturating at all ones
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_count <= '0;
        end else if (out_valid && out_ready && (perf_count != 16'hFFFF)) begin
            perf_count <= perf_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_class_vote_sched.sv
// =============================================================================
// tb_class_vote_sched
// -----------------------------------------------------------------------------
// Self-checking bench for class_vote_sched. The evaluator is modelled as a
// per-vector truth table indexed by (class, tree). Expected selects, latency
// and the winner are derived from slot arithmetic and vote counting.
// =============================================================================
module tb_class_vote_sched;

    localparam int N_FEAT   = 51;
    localparam int N_CLASS  = 5;
    localparam int N_TREE   = 2;
    localparam int EVAL_LAT = 1;
    localparam int CW       = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
    localparam int TW       = (N_TREE  > 1) ? $clog2(N_TREE)  : 1;
    localparam int VW       = $clog2(N_TREE + 1);
    localparam int S        = N_CLASS * N_TREE;
    localparam int SLOT_CYC = EVAL_LAT + 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N_FEAT-1:0] in_feat;
    logic [N_FEAT-1:0] ev_feat;
    logic [CW-1:0]     ev_class;
    logic [TW-1:0]     ev_tree;
    logic              ev_result;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_class;
    logic [VW-1:0]     out_votes;
    logic              out_tie;
`ifdef CLASS_VOTE_SCHED_PERF_CNT_EN
    logic [15:0]       perf_count;
`endif

    // Evaluator truth table for the vector in flight, bit index c*N_TREE+t.
    logic [S-1:0]      cur_tbl;

    int n_checks;
    int n_errors;
    int exp_perf;

    class_vote_sched #(
        .N_FEAT  (N_FEAT),
        .N_CLASS (N_CLASS),
        .N_TREE  (N_TREE),
        .EVAL_LAT(EVAL_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_feat  (in_feat),
        .ev_feat  (ev_feat),
        .ev_class (ev_class),
        .ev_tree  (ev_tree),
        .ev_result(ev_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_class(out_class),
        .out_votes(out_votes),
        .out_tie  (out_tie)
`ifdef CLASS_VOTE_SCHED_PERF_CNT_EN
        ,
        .perf_count(perf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Purely combinational evaluator.
    always_comb begin
        int idx;
        idx       = int'(ev_class) * N_TREE + int'(ev_tree);
        ev_result = (idx < S) ? cur_tbl[idx] : 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_FEAT-1:0] rand_feat();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[N_FEAT-1:0];
    endfunction

    // Reference: count votes per class, take the maximum, lowest index wins,
    // tie when more than one class reaches the maximum.
    function automatic void model(input logic [S-1:0] tbl, output int w_cls,
                                  output int w_votes, output bit w_tie);
        int cnt [N_CLASS];
        int best;
        int n_best;
        best   = -1;
        n_best = 0;
        w_cls  = 0;
        for (int c = 0; c < N_CLASS; c++) begin
            cnt[c] = 0;
            for (int t = 0; t < N_TREE; t++) cnt[c] += int'(tbl[c*N_TREE + t]);
            if (cnt[c] > best) best = cnt[c];
        end
        for (int c = N_CLASS - 1; c >= 0; c--) begin
            if (cnt[c] == best) begin
                w_cls = c;
                n_best++;
            end
        end
        w_votes = best;
        w_tie   = (n_best > 1);
    endfunction

    function automatic logic [S-1:0] class_tbl(input int c);
        logic [S-1:0] tbl;
        tbl = '0;
        for (int t = 0; t < N_TREE; t++) tbl[c*N_TREE + t] = 1'b1;
        return tbl;
    endfunction

    task automatic check_perf(input string tag);
`ifdef CLASS_VOTE_SCHED_PERF_CNT_EN
        check(tag, 64'(perf_count), 64'(exp_perf));
`endif
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".out_class"}, 64'(out_class), 64'd0);
        check({tag, ".out_votes"}, 64'(out_votes), 64'd0);
        check({tag, ".out_tie"},   64'(out_tie),   64'd0);
        check({tag, ".ev_class"},  64'(ev_class),  64'd0);
        check({tag, ".ev_tree"},   64'(ev_tree),   64'd0);
        check({tag, ".ev_feat"},   64'(ev_feat),   64'd0);
        check({tag, ".in_ready"},  64'(in_ready),  64'd1);
        check_perf({tag, ".perf"});
    endtask

    // Runs one vector from the accept cycle. hold = cycles out_ready stays
    // low once out_valid is up; abort_k > 0 pulses rst in that EVAL cycle.
    task automatic run_vector(input string name, input logic [S-1:0] tbl,
                              input int hold, input int abort_k);
        logic [N_FEAT-1:0] feat;
        int w_cls;
        int w_votes;
        bit w_tie;
        int slot;
        model(tbl, w_cls, w_votes, w_tie);

        check({name, ".accept_ready"}, 64'(in_ready), 64'd1);
        feat      = rand_feat();
        cur_tbl   = tbl;
        in_feat   = feat;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();

        for (int k = 1; k <= S * SLOT_CYC; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_feat  = rand_feat();
            slot     = (k - 1) / SLOT_CYC;
            check({name, ".sel_class"}, 64'(ev_class), 64'(slot / N_TREE));
            check({name, ".sel_tree"},  64'(ev_tree),  64'(slot % N_TREE));
            check({name, ".ev_feat"},   64'(ev_feat),  64'(feat));
            check({name, ".eval_ready"}, 64'(in_ready), 64'd0);
            check({name, ".eval_valid"}, 64'(out_valid), 64'd0);
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                check({name, ".rst_ready"}, 64'(in_ready), 64'd0);
                step();
                rst      = 1'b0;
                in_valid = 1'b0;
                exp_perf = 0;
                #1;
                check_idle_reset({name, ".abort"});
                return;
            end
            step();
        end

        // Cycle S*(EVAL_LAT+1)+1 after the accept edge: result presented.
        in_valid = 1'($urandom_range(0, 1));
        check({name, ".out_valid"}, 64'(out_valid), 64'd1);
        check({name, ".out_class"}, 64'(out_class), 64'(w_cls));
        check({name, ".out_votes"}, 64'(out_votes), 64'(w_votes));
        check({name, ".out_tie"},   64'(out_tie),   64'(w_tie));
        check({name, ".done_sel"},  64'({ev_class, ev_tree}), 64'd0);

        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            check({name, ".bp_valid"}, 64'(out_valid), 64'd1);
            check({name, ".bp_class"}, 64'(out_class), 64'(w_cls));
            check({name, ".bp_votes"}, 64'(out_votes), 64'(w_votes));
            check({name, ".bp_tie"},   64'(out_tie),   64'(w_tie));
            check({name, ".bp_ready"}, 64'(in_ready),  64'd0);
            step();
            in_valid = 1'($urandom_range(0, 1));
        end

        out_ready = 1'b1;
        check({name, ".hs_valid"}, 64'(out_valid), 64'd1);
        check({name, ".hs_ready"}, 64'(in_ready),  64'd0);
        step();
        in_valid = 1'b0;
        if (exp_perf < 16'hFFFF) exp_perf++;
        check({name, ".post_valid"}, 64'(out_valid), 64'd0);
        check({name, ".post_ready"}, 64'(in_ready),  64'd1);
        check_perf({name, ".perf"});
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_perf  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_feat   = '0;
        out_ready = 1'b1;
        cur_tbl   = '0;

        repeat (3) begin
            step();
            check("reset.in_ready", 64'(in_ready), 64'd0);
            check("reset.out_valid", 64'(out_valid), 64'd0);
        end
        rst = 1'b0;
        #1;
        check_idle_reset("reset");

        run_vector("class3", class_tbl(3), 0, 0);
        run_vector("tie14", class_tbl(1) | class_tbl(4), 0, 0);
        run_vector("zero", '0, 0, 0);
        run_vector("backpressure", S'({$urandom(), $urandom()}), 10, 0);
        run_vector("abort", S'({$urandom(), $urandom()}), 0, 7);

        // Three back-to-back vectors after the abort: handshake count is 3.
        run_vector("after_abort", class_tbl(3), 0, 0);
        run_vector("b2b_a", S'({$urandom(), $urandom()}), 0, 0);
        run_vector("b2b_b", S'({$urandom(), $urandom()}), 0, 0);

        for (int i = 0; i < 10; i++) begin
            run_vector("random", S'({$urandom(), $urandom()}),
                       int'($urandom_range(0, 3)), 0);
        end

        // Reset from DONE with out_ready low: aborts and clears everything.
        run_vector("pre_done_rst", class_tbl(2), 0, 0);
        in_valid = 1'b1;
        cur_tbl  = class_tbl(2);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (S * SLOT_CYC) step();
        check("done_rst.valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        exp_perf  = 0;
        #1;
        check_idle_reset("done_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/class_vote_sched.md
# class_vote_sched

Sequencer that time-shares one combinational decision-tree evaluator across an ensemble of per-class trees. It performs these steps for each feature vector:
- accepts the vector over a valid/ready handshake;
- walks every (class, tree) slot, driving the evaluator's select lines;
- samples the evaluator's 1-bit vote and accumulates votes per class;
- returns the winning class index.

It sits between the feature-capture front end and the result sink, in front of the synthesized tree netlists, which are muxed externally by `ev_class`/`ev_tree`.

## Interface

Parameters:
- `N_FEAT`, 51: feature vector width.
- `N_CLASS`, 5: number of classes; must be ≥ 2.
- `N_TREE`, 2: trees per class; must be ≥ 1.
- `EVAL_LAT`, 1: settle cycles allowed after a select change before sampling `ev_result`; range 0..15.
- Derived: `CW = max(1, clog2(N_CLASS))`, `TW = max(1, clog2(N_TREE))`, `VW = clog2(N_TREE+1)`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: feature vector valid.
- `in_ready` out 1: high only in IDLE with `rst` low.
- `in_feat` in `N_FEAT`: feature vector.
- `ev_feat` out `N_FEAT`: registered copy of the accepted vector, driven to the evaluator.
- `ev_class` out `CW`: class select for the evaluator.
- `ev_tree` out `TW`: tree select for the evaluator.
- `ev_result` in 1: evaluator vote for the current select.
- `out_valid` out 1: result valid.
- `out_ready` in 1: sink ready.
- `out_class` out `CW`: winning class index.
- `out_votes` out `VW`: vote count of the winner.
- `out_tie` out 1: another class equalled the winner's count.

## Operation

- **FSM states:** IDLE, EVAL, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `in_feat` into `ev_feat`, clear all vote counters, set slot to (class 0, tree 0), clear the wait counter, go to EVAL.
- **EVAL:**
  - Selects hold the current slot.
  - The wait counter increments each cycle.
  - When wait == `EVAL_LAT`, sample `ev_result` and add it to `votes[ev_class]`, clear the wait counter, and advance the slot:
    - tree increments first;
    - at tree `N_TREE-1`, tree wraps to 0 and class increments.
- **Running winner:** updated on the sample of each class's last tree, using that class's final count (including the current sample).
  - Class 0 always loads as best, with tie=0.
  - Later classes: a strictly greater count replaces best and clears tie.
  - An equal count sets tie.
  - On ties, the lowest index wins.
- **End of EVAL:** after the sample of slot (`N_CLASS-1`, `N_TREE-1`), go to DONE.
- **DONE:**
  - `out_valid`=1.
  - `out_class`/`out_votes`/`out_tie` hold stable until `out_valid && out_ready`, then go to IDLE.
  - `in_ready`=0 throughout DONE.
- **Out-of-range selects:** `ev_class`/`ev_tree` never exceed `N_CLASS-1`/`N_TREE-1`.
- **Outside EVAL:** selects hold 0.
- **Vote counters:** `VW` bits wide; they cannot overflow because they are bounded by `N_TREE`.

## Timing

- **Reset values:**
  - `in_ready`=0 while `rst` is high.
  - `ev_feat`=0, `ev_class`=0, `ev_tree`=0.
  - `out_valid`=0, `out_class`=0, `out_votes`=0, `out_tie`=0.
  - State is IDLE.
- **Slot timing:** each slot occupies exactly `EVAL_LAT+1` cycles.
- **Latency:**
  - With the accept edge at cycle 0, EVAL spans cycles 1..S·(`EVAL_LAT`+1), where S = `N_CLASS`·`N_TREE`.
  - `out_valid` rises in cycle S·(`EVAL_LAT`+1)+1.
  - With defaults, `out_valid` rises in cycle 21.
- **Throughput:** at most one vector per S·(`EVAL_LAT`+1)+2 cycles, with `out_ready` tied high.
- **Back-to-back:** the earliest next accept is the cycle after the output handshake. There is no overlap of vectors.
- **`in_valid` outside IDLE:** ignored. `in_feat` changes during EVAL do not affect `ev_feat`.
- **`out_ready` held low:** DONE persists indefinitely with outputs stable.
- **`rst` mid-EVAL or in DONE:** aborts; votes are discarded, no `out_valid` is produced, and the next cycle is IDLE with reset values.
- **`EVAL_LAT`=0:** sampling occurs in the same cycle the select is presented; the evaluator must be purely combinational.

## Configuration

- **Macro:** `CLASS_VOTE_SCHED_PERF_CNT_EN`.
- **Defined:**
  - Adds output port `perf_count` (16 bits): the number of completed output handshakes.
  - Saturates at 16'hFFFF and resets to 0.
  - Increments in the cycle of `out_valid && out_ready`.
- **Undefined:** the port and counter are absent; all other behaviour is identical.

## Test plan

- **Reset then single vector** (defaults, `EVAL_LAT`=1, `out_ready`=1; evaluator model returns 1 only for class 3, both trees):
  - `out_valid` in cycle 21 after accept.
  - `out_class`=3, `out_votes`=2, `out_tie`=0.
- **Tie** (class 1 and class 4 each get 2 votes, all others 0):
  - `out_class`=1, `out_votes`=2, `out_tie`=1.
- **All-zero votes:**
  - `out_class`=0, `out_votes`=0, `out_tie`=1.
- **Backpressure** (`out_ready`=0 for 10 cycles after `out_valid`):
  - Outputs stable and `in_ready`=0 throughout.
  - Handshake on the 11th cycle.
  - `in_ready`=1 on the next cycle.
- **Abort** (`rst` pulsed in cycle 7 of EVAL, new vector accepted afterwards):
  - No `out_valid` for the aborted vector.
  - The second result is correct.
  - Selects observed as (0,0),(0,1),(1,0)… with each slot held 2 cycles.
- **Perf counter** (macro defined, 3 back-to-back vectors):
  - `perf_count` reads 3.
  - Resets to 0 on `rst`.
